// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbitration controller: op codes,
// default widths and the controller state encoding.
package calc_pkg;

  localparam int DW_DEF = 10;
  localparam int RW_DEF = 20;

  localparam logic [3:0] OP_FACT = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_MOD  = 4'd5;
  localparam logic [3:0] OP_GCD  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_NCR  = 4'd8;
  localparam logic [3:0] OP_POW  = 4'd9;
  localparam logic [3:0] OP_SQRT = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } calc_state_t;

  // Requests the datapath cannot answer: unknown op code or a zero divisor.
  function automatic logic op_is_err(input logic [3:0] op, input logic b_zero);
    return (op > OP_SQRT) || (((op == OP_DIV) || (op == OP_MOD)) && b_zero);
  endfunction

endpackage

// File: rtl/calc_arb_ctrl_if.sv
// Bundle of the two requester ports, the shared datapath port and the
// response port of calc_arb_ctrl.
interface calc_arb_ctrl_if import calc_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) ();

  logic          req0_valid;
  logic          req0_ready;
  logic [3:0]    req0_op;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic [3:0]    req1_op;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [3:0]    dp_op_code;
  logic [DW-1:0] dp_a;
  logic [DW-1:0] dp_b;
  logic [RW-1:0] dp_res;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [RW-1:0] rsp_res;
  logic          rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output dp_res, rsp_ready,
    input  req0_ready, req1_ready, dp_op_code, dp_a, dp_b,
    input  rsp_valid, rsp_id, rsp_res, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  dp_res, rsp_ready,
    output req0_ready, req1_ready, dp_op_code, dp_a, dp_b,
    output rsp_valid, rsp_id, rsp_res, rsp_err
  );

endinterface

// File: rtl/calc_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, on contention the one
// not granted last wins; req0 is favoured out of reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic       last1_r;
  logic [1:0] grant_s;

  // One-hot grant from the request pair and the last-winner pointer.
  always_comb begin
    grant_s = 2'b00;
    case (valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last1_r ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  assign grant = grant_s;

  // Pointer remembers whether req1 won the last accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last1_r <= 1'b1;
    end else if (advance) begin
      last1_r <= grant_s[1];
    end
  end

endmodule

// File: rtl/calc_arb_ctrl.sv
// Arbitrates two requesters onto one combinational calculator datapath, waits
// a fixed settle time per operation and returns the result with its owner id.
module calc_arb_ctrl import calc_pkg::*; #(
  parameter int DW         = DW_DEF,
  parameter int RW         = RW_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  calc_arb_ctrl_if.slave     bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  calc_state_t   state_r;
  logic [3:0]    cnt_r;
  logic [3:0]    dp_op_r;
  logic [DW-1:0] dp_a_r;
  logic [DW-1:0] dp_b_r;
  logic          rsp_valid_r;
  logic          rsp_id_r;
  logic [RW-1:0] rsp_res_r;
  logic          rsp_err_r;

  logic [1:0]    grant_s;
  logic [1:0]    ready_s;
  logic [1:0]    xfer_s;
  logic          sel_id_s;
  logic [3:0]    sel_op_s;
  logic [DW-1:0] sel_a_s;
  logic [DW-1:0] sel_b_s;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({bus.req1_valid, bus.req0_valid}),
    .advance (|xfer_s),
    .grant   (grant_s)
  );

  // Ready is offered only while idle and never while reset is applied.
  always_comb begin
    ready_s = 2'b00;
    if ((state_r == IDLE) && !rst) begin
      ready_s = grant_s;
    end else begin
      ready_s = 2'b00;
    end
  end

  assign xfer_s = {bus.req1_valid, bus.req0_valid} & ready_s;

  // Operand mux for the requester being accepted this cycle.
  always_comb begin
    sel_id_s = 1'b0;
    sel_op_s = bus.req0_op;
    sel_a_s  = bus.req0_a;
    sel_b_s  = bus.req0_b;
    if (xfer_s[1]) begin
      sel_id_s = 1'b1;
      sel_op_s = bus.req1_op;
      sel_a_s  = bus.req1_a;
      sel_b_s  = bus.req1_b;
    end else begin
      sel_id_s = 1'b0;
    end
  end

  // Controller FSM with the datapath drive and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      dp_op_r     <= 4'd0;
      dp_a_r      <= {DW{1'b0}};
      dp_b_r      <= {DW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_res_r   <= {RW{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|xfer_s) begin
            dp_op_r  <= sel_op_s;
            dp_a_r   <= sel_a_s;
            dp_b_r   <= sel_b_s;
            rsp_id_r <= sel_id_s;
            // Errors are answered at once; the datapath output is never used.
            if (op_is_err(sel_op_s, sel_b_s == {DW{1'b0}})) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_res_r   <= {RW{1'b0}};
              rsp_err_r   <= 1'b1;
            end else begin
              state_r <= SETTLE;
              cnt_r   <= SETTLE_LAST;
            end
          end
        end
        SETTLE: begin
          if (cnt_r == 4'd0) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_res_r   <= bus.dp_res;
            rsp_err_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready_s[0];
  assign bus.req1_ready = ready_s[1];
  assign bus.dp_op_code = dp_op_r;
  assign bus.dp_a       = dp_a_r;
  assign bus.dp_b       = dp_b_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_res    = rsp_res_r;
  assign bus.rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_calc_arb_ctrl.sv
// Scoreboard bench for calc_arb_ctrl with a behavioural calculator datapath.
module tb_calc_arb_ctrl;

  localparam int DW = 10;
  localparam int RW = 20;
  localparam int SC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_arb_ctrl_if #(.DW(DW), .RW(RW)) bus ();

  calc_arb_ctrl #(.DW(DW), .RW(RW), .SETTLE_CYC(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          id;
    logic [RW-1:0] res;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] calc_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    longint unsigned r, x, y, t;
    r = 0;
    case (op)
      4'd0: begin
        r = 1;
        for (int i = 2; i <= int'(a) && i <= 20; i++) r = r * longint'(i);
      end
      4'd1: r = longint'(a) + longint'(b);
      4'd2: r = longint'(a) - longint'(b);
      4'd3: r = (a > b) ? 1 : 0;
      4'd4: r = (b != 0) ? longint'(a / b) : 0;
      4'd5: r = (b != 0) ? longint'(a % b) : 0;
      4'd6: begin
        x = longint'(a); y = longint'(b);
        while (y != 0) begin t = x % y; x = y; y = t; end
        r = x;
      end
      4'd7: r = longint'(a) * longint'(b);
      4'd8: begin
        if (b > a) r = 0;
        else begin
          r = 1;
          for (int i = 1; i <= int'(b); i++) r = r * longint'(int'(a) - int'(b) + i) / longint'(i);
        end
      end
      4'd9: begin
        r = 1;
        for (int i = 0; i < int'(b); i++) r = r * longint'(a);
      end
      4'd10: begin
        r = 0;
        while ((r + 1) * (r + 1) <= longint'(a)) r++;
      end
      default: r = 0;
    endcase
    return RW'(r);
  endfunction

  // Behavioural datapath fed from the controller's dp_* outputs.
  always_comb bus.dp_res = calc_ref(bus.dp_op_code, bus.dp_a, bus.dp_b);

  function automatic logic ref_err(input logic [3:0] op, input logic [DW-1:0] b);
    return (op > 4'd10) || (((op == 4'd4) || (op == 4'd5)) && (b == 0));
  endfunction

  task automatic set_req(input int id, input logic v, input logic [3:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic push_exp(input int id, input logic [3:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
    exp_t e;
    e.id  = 1'(id);
    e.err = ref_err(op, b);
    e.res = e.err ? {RW{1'b0}} : calc_ref(op, a, b);
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input int id, input logic [3:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b);
    int n = 0;
    push_exp(id, op, a, b);
    set_req(id, 1'b1, op, a, b);
    #1;
    while (((id == 0) ? bus.req0_ready : bus.req1_ready) !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_wait", 32'(n < 50), 32'd1);
    @(negedge clk);
    set_req(id, 1'b0, op, a, b);
  endtask

  // Waits for a response, compares it to the scoreboard, optionally stalls
  // rsp_ready for 'hold' cycles, then accepts it.
  task automatic collect(input int exp_lat, input int hold);
    exp_t e;
    int   lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (sb_q.size() == 0) begin
      chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_id",    32'(bus.rsp_id),    32'(e.id));
      chk("rsp_res",   32'(bus.rsp_res),   32'(e.res));
      chk("rsp_err",   32'(bus.rsp_err),   32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(bus.rsp_valid),  32'd1);
        chk("hold_res",   32'(bus.rsp_res),    32'(e.res));
        chk("hold_id",    32'(bus.rsp_id),     32'(e.id));
        chk("hold_rdy0",  32'(bus.req0_ready), 32'd0);
        chk("hold_rdy1",  32'(bus.req1_ready), 32'd0);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("rspcyc_rdy0", 32'(bus.req0_ready), 32'd0);
    chk("rspcyc_rdy1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  // Both requesters valid from an arbiter state favouring req0.
  task automatic both_valid();
    push_exp(0, 4'd7, 10'd3, 10'd4);
    push_exp(1, 4'd9, 10'd2, 10'd3);
    set_req(0, 1'b1, 4'd7, 10'd3, 10'd4);
    set_req(1, 1'b1, 4'd9, 10'd2, 10'd3);
    #1;
    chk("both_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("both_rdy1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    set_req(0, 1'b0, 4'd7, 10'd3, 10'd4);
    chk("busy_rdy1", 32'(bus.req1_ready), 32'd0);
    collect(1 + SC, 0);
    #1;
    chk("rr_rdy1", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    set_req(1, 1'b0, 4'd9, 10'd2, 10'd3);
    collect(1 + SC, 0);
  endtask

  initial begin
    logic [3:0]    op;
    logic [DW-1:0] a, b;
    int            id;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'd1, 10'd1, 10'd1);
    set_req(1, 1'b1, 4'd1, 10'd1, 10'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
    chk("rst_rdy1",  32'(bus.req1_ready), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid),  32'd0);
    chk("rst_dp_op", 32'(bus.dp_op_code), 32'd0);
    chk("rst_dp_a",  32'(bus.dp_a),       32'd0);
    chk("rst_res",   32'(bus.rsp_res),    32'd0);
    set_req(0, 1'b0, 4'd0, 10'd0, 10'd0);
    set_req(1, 1'b0, 4'd0, 10'd0, 10'd0);
    rst = 1'b0;
    @(negedge clk);

    both_valid();

    send(0, 4'd1, 10'd10, 10'd5);
    collect(1 + SC, 0);

    send(1, 4'd4, 10'd20, 10'd0);
    collect(1, 0);
    send(1, 4'd12, 10'd7, 10'd3);
    collect(1, 0);
    send(0, 4'd5, 10'd9, 10'd0);
    collect(1, 0);
    send(0, 4'd4, 10'd9, 10'd2);
    collect(1 + SC, 0);
    send(1, 4'd15, 10'd1, 10'd1);
    collect(1, 0);

    // Stalled response with a competing request waiting, plus a dropped request.
    send(0, 4'd2, 10'd9, 10'd4);
    set_req(0, 1'b1, 4'd7, 10'd8, 10'd8);
    @(negedge clk);
    set_req(0, 1'b0, 4'd7, 10'd8, 10'd8);
    set_req(1, 1'b1, 4'd3, 10'd6, 10'd2);
    collect(SC, 5);
    send(1, 4'd3, 10'd6, 10'd2);
    collect(1 + SC, 0);

    for (int k = 0; k < 8; k++) begin
      id = int'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      a  = DW'($urandom_range(0, 12));
      b  = DW'($urandom_range(0, 12));
      send(id, op, a, b);
      collect(ref_err(op, b) ? 1 : 1 + SC, 0);
    end

    // Reset in SETTLE abandons the operation; req0 left last winner.
    set_req(0, 1'b1, 4'd7, 10'd5, 10'd6);
    #1;
    chk("pre_rst_rdy0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, 4'd7, 10'd5, 10'd6);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.rsp_valid),  32'd0);
    chk("arst_dp_op", 32'(bus.dp_op_code), 32'd0);
    chk("arst_dp_a",  32'(bus.dp_a),       32'd0);
    chk("arst_dp_b",  32'(bus.dp_b),       32'd0);
    chk("arst_res",   32'(bus.rsp_res),    32'd0);
    chk("arst_id",    32'(bus.rsp_id),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
    end
    both_valid();

    chk("sb_left", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_arb_ctrl.md
CALC_ARB_CTRL -- requirements
Module: calc_arb_ctrl

Interface
REQ-001 Parameter DW, default 10, operand width.
REQ-002 Parameter RW, default 20, result width.
REQ-003 Parameter SETTLE_CYC, default 2, datapath settle cycles per operation, legal range 1..15.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req0_valid / req1_valid  input  1  requester N offers an operation.
REQ-007 req0_ready / req1_ready  output  1  controller accepts requester N this cycle.
REQ-008 req0_op / req1_op  input  4  operation code, 0..10 legal.
REQ-009 req0_a, req0_b / req1_a, req1_b  input  DW  operands.
REQ-010 dp_op_code  output  4  op code driven to the shared calculator datapath.
REQ-011 dp_a, dp_b  output  DW  operands to the datapath (dp_a feeds num/a/n/num_sqrt, dp_b feeds b/r).
REQ-012 dp_res  input  RW  combinational datapath result.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_id  output  1  requester that owns the response.
REQ-016 rsp_res  output  RW  result.
REQ-017 rsp_err  output  1  illegal op code or divide by zero.

Function
REQ-018 FSM states: IDLE, SETTLE, RESP.
REQ-019 reqN_ready SHALL be high only in IDLE, only for the granted requester, at most one per cycle.
REQ-020 Grant in IDLE: single valid requester wins; if both valid, the requester not granted last wins; after reset req0 has priority.
REQ-021 On transfer (valid & ready), op/a/b SHALL be latched into dp_op_code/dp_a/dp_b and the grant pointer updated.
REQ-022 Legal op with no error: IDLE -> SETTLE; a counter runs SETTLE_CYC cycles with dp outputs held stable.
REQ-023 At end of SETTLE, dp_res SHALL be captured into rsp_res, rsp_err=0, state -> RESP.
REQ-024 Op code 11..15, or op 4/5 with b=0: IDLE -> RESP directly; rsp_res=0, rsp_err=1; datapath not waited on.
REQ-025 Latency: transfer at cycle T gives rsp_valid at T+1+SETTLE_CYC (legal) or T+1 (error).
REQ-026 RESP: rsp_valid, rsp_id, rsp_res, rsp_err held stable until rsp_ready=1; on that cycle state -> IDLE, rsp_valid drops next cycle.
REQ-027 No new request SHALL be accepted in the rsp_ready cycle; earliest next acceptance is the following cycle.
REQ-028 Requests deasserted before acceptance SHALL be dropped without side effects.
REQ-029 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-030 rst SHALL force IDLE, settle counter 0, grant pointer to favour req0, all outputs 0 (reqN_ready, dp_*, rsp_*).
REQ-031 rst mid-SETTLE or mid-RESP SHALL abandon the operation; no response is issued after reset release.

Structure
REQ-032 Shared package calc_pkg SHALL hold op code constants (OP_FACT=0 .. OP_SQRT=10), DW/RW defaults and the FSM state enumeration.
REQ-033 Two-way round-robin arbitration SHALL be a sub-module rr_arb2 (inputs valid pair, advance; output one-hot grant).

Verification
REQ-034 req0 op=1 a=10 b=5, rsp_ready=1 -> rsp_valid at T+3, rsp_id=0, rsp_res=15, rsp_err=0.
REQ-035 Both valid same cycle, req0 op=7 a=3 b=4, req1 op=9 a=2 b=3 -> req0 served first (12), then req1 (8), rsp_id 0 then 1.
REQ-036 req1 op=4 a=20 b=0 -> rsp_valid at T+1, rsp_err=1, rsp_res=0; op=12 -> same error response.
REQ-037 rsp_ready held low 5 cycles in RESP -> response stable, both reqN_ready low, accepted on rsp_ready rise.
REQ-038 rst asserted in SETTLE -> all outputs 0 immediately, no rsp_valid afterwards, next request granted to req0.
